// File: rtl/rec_play_ctrl_pkg.sv
// Shared definitions for the record/playback controller: state codes,
// default key scan codes and the SRAM address width.
package rec_play_ctrl_pkg;

  localparam int ADDR_W = 20;

  localparam logic [7:0]        KEY_REC_DEF  = 8'h22;
  localparam logic [7:0]        KEY_PLAY_DEF = 8'h21;
  localparam logic [7:0]        KEY_STOP_DEF = 8'h1A;
  localparam logic [ADDR_W-1:0] ADDR_MAX_DEF = 20'hFFFFF;

  // Codes are visible on o_state and consumed by the screen module.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd1,
    ST_RECD       = 3'd2,
    ST_RECD_PAUSE = 3'd3,
    ST_PLAY       = 3'd4,
    ST_PLAY_PAUSE = 3'd5
  } state_e;

endpackage

// File: rtl/rec_play_ctrl_key_press_det.sv
// Single-key press detector: fires only on the first cycle a key code
// appears, so a held key yields exactly one press.
module key_press_det #(
  parameter logic [7:0] KEY = 8'h00
) (
  input  logic [7:0] key_code,
  input  logic [7:0] prev_code,
  output logic       press
);

  assign press = (key_code == KEY) && (prev_code != KEY);

endmodule

// File: rtl/rec_play_ctrl.sv
// Record/playback controller: turns keyboard presses and address progress
// into recorder/player controls and steers the SRAM address and write enable.
module rec_play_ctrl
  import rec_play_ctrl_pkg::*;
#(
  parameter logic [7:0]        KEY_REC  = KEY_REC_DEF,
  parameter logic [7:0]        KEY_PLAY = KEY_PLAY_DEF,
  parameter logic [7:0]        KEY_STOP = KEY_STOP_DEF,
  parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_key_code,
  input  logic [ADDR_W-1:0] i_addr_record,
  input  logic [ADDR_W-1:0] i_addr_play,
  output logic [2:0]        o_state,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic              o_has_rec,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n
);

  state_e     state;
  logic [7:0] prev_key;
  logic       rec_press;
  logic       play_press;
  logic       stop_press;

  // Reset value 00 makes a key held through reset count as a fresh press.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) prev_key <= 8'h00;
    else          prev_key <= i_key_code;
  end

  key_press_det #(.KEY(KEY_REC)) u_det_rec (
    .key_code  (i_key_code),
    .prev_code (prev_key),
    .press     (rec_press)
  );

  key_press_det #(.KEY(KEY_PLAY)) u_det_play (
    .key_code  (i_key_code),
    .prev_code (prev_key),
    .press     (play_press)
  );

  key_press_det #(.KEY(KEY_STOP)) u_det_stop (
    .key_code  (i_key_code),
    .prev_code (prev_key),
    .press     (stop_press)
  );

  // Each if/else chain encodes the priority toggle key > stop > address limit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      o_end_addr  <= '0;
      o_has_rec   <= 1'b0;
      o_rec_start <= 1'b0;
    end else begin
      o_rec_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rec_press) begin
            state       <= ST_RECD;
            o_rec_start <= 1'b1;
          end else if (play_press && o_has_rec) begin
            state <= ST_PLAY;
          end
        end
        ST_RECD: begin
          if (rec_press) begin
            state <= ST_RECD_PAUSE;
          end else if (stop_press || (i_addr_record >= ADDR_MAX)) begin
            state      <= ST_IDLE;
            o_end_addr <= i_addr_record;
            o_has_rec  <= (i_addr_record != '0);
          end
        end
        ST_RECD_PAUSE: begin
          if (rec_press) begin
            state       <= ST_RECD;
            o_rec_start <= 1'b1;
          end else if (stop_press) begin
            state      <= ST_IDLE;
            o_end_addr <= i_addr_record;
            o_has_rec  <= (i_addr_record != '0);
          end
        end
        ST_PLAY: begin
          if (play_press)                                    state <= ST_PLAY_PAUSE;
          else if (stop_press || (i_addr_play >= o_end_addr)) state <= ST_IDLE;
        end
        ST_PLAY_PAUSE: begin
          if (play_press)      state <= ST_PLAY;
          else if (stop_press) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_state      = state;
  assign o_rec_pause  = (state == ST_RECD_PAUSE);
  assign o_play_start = (state == ST_PLAY);
  assign o_play_pause = (state == ST_PLAY_PAUSE);
  assign o_rec_stop   = (state == ST_IDLE);
  assign o_play_stop  = (state == ST_IDLE);

  assign o_sram_addr  = (state == ST_RECD) ? i_addr_record : i_addr_play;
  assign o_sram_we_n  = (state != ST_RECD);

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed testbench for rec_play_ctrl: drives key and address sequences and
// compares outputs against hand-computed values.
module tb_rec_play_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [7:0]  i_key_code;
  logic [19:0] i_addr_record;
  logic [19:0] i_addr_play;
  logic [2:0]  o_state;
  logic        o_rec_start, o_rec_pause, o_rec_stop;
  logic        o_play_start, o_play_pause, o_play_stop;
  logic [19:0] o_end_addr;
  logic        o_has_rec;
  logic [19:0] o_sram_addr;
  logic        o_sram_we_n;

  int n_checks = 0;
  int n_errors = 0;

  rec_play_ctrl dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_key_code    (i_key_code),
    .i_addr_record (i_addr_record),
    .i_addr_play   (i_addr_play),
    .o_state       (o_state),
    .o_rec_start   (o_rec_start),
    .o_rec_pause   (o_rec_pause),
    .o_rec_stop    (o_rec_stop),
    .o_play_start  (o_play_start),
    .o_play_pause  (o_play_pause),
    .o_play_stop   (o_play_stop),
    .o_end_addr    (o_end_addr),
    .o_has_rec     (o_has_rec),
    .o_sram_addr   (o_sram_addr),
    .o_sram_we_n   (o_sram_we_n)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  int rec_start_cnt;
  int state_changes;
  logic [2:0] last_state;

  initial begin
    i_rst_n       = 1'b0;
    i_key_code    = 8'h00;
    i_addr_record = 20'h0;
    i_addr_play   = 20'h0;
    #23;
    check("rst_state",     o_state, 3'd1);
    check("rst_end_addr",  o_end_addr, 20'h0);
    check("rst_has_rec",   o_has_rec, 1'b0);
    check("rst_rec_start", o_rec_start, 1'b0);
    check("rst_we_n",      o_sram_we_n, 1'b1);
    check("rst_rec_stop",  o_rec_stop, 1'b1);
    check("rst_play_stop", o_play_stop, 1'b1);
    i_rst_n = 1'b1;
    tick(1);

    // Play with no recording is ignored
    i_key_code = 8'h21; tick(1);
    check("s2_state",      o_state, 3'd1);
    check("s2_play_start", o_play_start, 1'b0);
    i_key_code = 8'h00; tick(1);

    // Record to 0x100 then stop
    i_key_code = 8'h22; tick(1);
    check("s1_state_recd", o_state, 3'd2);
    check("s1_rec_start",  o_rec_start, 1'b1);
    check("s1_we_n",       o_sram_we_n, 1'b0);
    i_key_code = 8'h00; i_addr_record = 20'h00100; i_addr_play = 20'h00055; tick(1);
    check("s1_rec_start_off", o_rec_start, 1'b0);
    check("s1_state_hold",    o_state, 3'd2);
    check("s1_sram_addr_rec", o_sram_addr, 20'h00100);
    i_key_code = 8'h1A; tick(1);
    check("s1_state_idle", o_state, 3'd1);
    check("s1_end_addr",   o_end_addr, 20'h00100);
    check("s1_has_rec",    o_has_rec, 1'b1);
    check("s1_sram_addr_play", o_sram_addr, 20'h00055);
    check("s1_we_n_idle",  o_sram_we_n, 1'b1);
    i_key_code = 8'h00; tick(1);

    // Play until the end address is reached
    i_addr_play = 20'h0;
    i_key_code = 8'h21; tick(1);
    check("s3_state_play", o_state, 3'd4);
    check("s3_play_start", o_play_start, 1'b1);
    i_key_code = 8'h00; i_addr_play = 20'h000FF; tick(1);
    check("s3_state_play_ff", o_state, 3'd4);
    check("s3_sram_addr",     o_sram_addr, 20'h000FF);
    i_addr_play = 20'h00100; tick(1);
    check("s3_state_end", o_state, 3'd1);
    check("s3_play_stop", o_play_stop, 1'b1);
    i_addr_play = 20'h0;

    // Held key produces a single transition
    i_addr_record = 20'h00010;
    i_key_code = 8'h22; tick(1);
    check("s4_state_recd", o_state, 3'd2);
    rec_start_cnt = 0;
    state_changes = 0;
    last_state = o_state;
    for (int i = 0; i < 49; i++) begin
      tick(1);
      if (o_rec_start) rec_start_cnt++;
      if (o_state != last_state) state_changes++;
      last_state = o_state;
    end
    check("s4_hold_changes", state_changes, 0);
    check("s4_hold_pulses",  rec_start_cnt, 0);
    i_key_code = 8'h00; tick(1);
    i_key_code = 8'h22; tick(1);
    check("s4_state_pause", o_state, 3'd3);
    check("s4_rec_pause",   o_rec_pause, 1'b1);
    check("s4_we_n_pause",  o_sram_we_n, 1'b1);
    i_key_code = 8'h00; tick(1);
    i_key_code = 8'h22; tick(1);
    check("s4_state_resume", o_state, 3'd2);
    check("s4_rec_start2",   o_rec_start, 1'b1);
    i_key_code = 8'h00; tick(1);

    // Stop with captured address 0 clears has_rec; play then ignored
    i_addr_record = 20'h0;
    i_key_code = 8'h1A; tick(1);
    check("s4_state_stop0", o_state, 3'd1);
    check("s4_has_rec_clr", o_has_rec, 1'b0);
    i_key_code = 8'h00; tick(1);
    i_key_code = 8'h21; tick(1);
    check("s4_play_ignored", o_state, 3'd1);
    i_key_code = 8'h00; tick(1);

    // Memory-full auto-stop, then toggle beats address limit in PLAY
    i_key_code = 8'h22; tick(1);
    check("s5_state_recd", o_state, 3'd2);
    i_key_code = 8'h00; i_addr_record = 20'hFFFFF; tick(1);
    check("s5_state_full", o_state, 3'd1);
    check("s5_end_addr",   o_end_addr, 20'hFFFFF);
    check("s5_has_rec",    o_has_rec, 1'b1);
    i_addr_record = 20'h0;
    i_key_code = 8'h21; tick(1);
    check("s5_state_play", o_state, 3'd4);
    i_key_code = 8'h00; tick(1);
    i_key_code = 8'h21; i_addr_play = 20'hFFFFF; tick(1);
    check("s5_state_ppause", o_state, 3'd5);
    check("s5_play_pause",   o_play_pause, 1'b1);
    i_key_code = 8'h00; tick(1);
    check("s5_ppause_hold",  o_state, 3'd5);
    i_key_code = 8'h1A; tick(1);
    check("s5_state_stop",   o_state, 3'd1);
    i_key_code = 8'h00; i_addr_play = 20'h0; tick(1);

    // Asynchronous reset during record-pause
    i_addr_record = 20'h00200;
    i_key_code = 8'h22; tick(1);
    i_key_code = 8'h00; tick(1);
    i_key_code = 8'h22; tick(1);
    check("s6_state_pause", o_state, 3'd3);
    i_key_code = 8'h00;
    #2 i_rst_n = 1'b0;
    #1;
    check("s6_state_rst",   o_state, 3'd1);
    check("s6_has_rec_rst", o_has_rec, 1'b0);
    check("s6_end_rst",     o_end_addr, 20'h0);
    check("s6_we_n_rst",    o_sram_we_n, 1'b1);

    // Key held across reset release counts as a press
    i_key_code = 8'h22;
    #3 i_rst_n = 1'b1;
    tick(1);
    check("rst_held_press", o_state, 3'd2);
    check("rst_held_start", o_rec_start, 1'b1);
    tick(2);
    check("rst_held_once",  o_state, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
